axi_sram_burst: RTL
===================

# axi_sram_burst

AXI4 slave SRAM model for the simulation environment that serves CPU and DMA traffic from a word-organised array of 2**MEM_ADDR_WIDTH words. It supports FIXED, INCR and WRAP bursts with narrow transfers and unaligned starts. Out-of-range and reserved-burst accesses return SLVERR instead of aliasing, and an optional registered read output stage gives full backpressure.
## Interface
- DATA_WIDTH, 64: data bus width in bits; power of two, at least 8. STRB = DATA_WIDTH/8.
- ADDR_WIDTH, 32: AXI byte-address width.
- ID_WIDTH, 8: AXI ID width.
- MEM_ADDR_WIDTH, 16: log2 of the array depth in words; byte capacity is STRB*2**MEM_ADDR_WIDTH.
- PIPELINE_OUTPUT, 0: 1 adds one registered R output stage.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_axi_awid  in  ID_WIDTH  write ID
- s_axi_awaddr  in  ADDR_WIDTH  write start byte address
- s_axi_awlen  in  8  write beats minus 1
- s_axi_awsize  in  3  log2 bytes per beat
- s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- s_axi_awvalid  in  1  AW valid
- s_axi_awready  out  1  AW ready
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  STRB  byte lane enables
- s_axi_wlast  in  1  last beat; ignored, beat count comes from awlen
- s_axi_wvalid  in  1  W valid
- s_axi_wready  out  1  W ready
- s_axi_bid  out  ID_WIDTH  response ID, equal to awid
- s_axi_bresp  out  2  00 OKAY, 10 SLVERR
- s_axi_bvalid  out  1  B valid
- s_axi_bready  in  1  B ready
- s_axi_arid  in  ID_WIDTH  read ID
- s_axi_araddr  in  ADDR_WIDTH  read start byte address
- s_axi_arlen  in  8  read beats minus 1
- s_axi_arsize  in  3  log2 bytes per beat
- s_axi_arburst  in  2  burst type, encoded as for awburst
- s_axi_arvalid  in  1  AR valid
- s_axi_arready  out  1  AR ready
- s_axi_rid  out  ID_WIDTH  read ID, equal to arid
- s_axi_rdata  out  DATA_WIDTH  read data; 0 for error beats
- s_axi_rresp  out  2  per-beat response, 00 OKAY or 10 SLVERR
- s_axi_rlast  out  1  last read beat
- s_axi_rvalid  out  1  R valid
- s_axi_rready  in  1  R ready
## Operation
- **Address generation**
  - Word index is addr >> log2(STRB). A beat is in range when addr < STRB*2**MEM_ADDR_WIDTH; range is checked per beat, so a burst can cross the top of the array. Size is clamped to log2(STRB).
  - FIXED: address stays constant for every beat.
  - INCR: next = (addr & ~((1<<size)-1)) + (1<<size), so an unaligned start is aligned from beat 1.
  - WRAP: valid only for len 1, 3, 7 or 15; any other len is treated as INCR. Boundary B = (len+1)<<size; next = (addr & ~(B-1)) | ((addr + (1<<size)) & (B-1)).
  - Reserved burst (11): every beat is SLVERR.
- **Write FSM** (IDLE, BURST, RESP)
  - IDLE: awready=1. An AW handshake latches id/addr/len/size/burst and moves to BURST.
  - BURST: wready=1. Each W handshake writes the strobed lanes, but only for in-range beats of a non-reserved burst. After len+1 beats go to RESP.
  - RESP: bvalid=1, bresp=SLVERR if any beat errored, else OKAY. Return to IDLE on the B handshake.
- **Read FSM** (IDLE, BURST)
  - IDLE: arready=1. An AR handshake latches the command and moves to BURST.
  - BURST: a beat is issued whenever the output slot is free or is being drained that cycle. Per beat: rresp = OKAY with array data, or SLVERR with rdata=0. rlast is set on beat len. Return to IDLE after the last beat is issued.
- **Channel independence:** read and write channels are fully independent. A read and a write to the same word in the same cycle returns the old data (read-first).
## Timing
- **Reset values:** all outputs are 0. awready and arready rise on the first clk edge after rst_n deasserts.
- **Handshake stability:** R outputs are held stable while rvalid && !rready. bid/bresp are held stable while bvalid && !bready.
- **Write latency:** AW handshake at cycle T gives wready=1 at T+1. The last W handshake at T gives bvalid=1 at T+1, with wready=0 from T+1. awready is low from the AW handshake until the cycle after the B handshake.
- **Read latency and throughput:**
  - AR handshake at T gives the first rvalid at T+1 (PIPELINE_OUTPUT=0) or T+2 (PIPELINE_OUTPUT=1).
  - With rready held high, bursts run at one beat per cycle with no bubbles.
  - arready returns the cycle after the last beat is issued.
  - With PIPELINE_OUTPUT=1, no beat may be lost or duplicated under any rready pattern.
- **Reset mid-burst:** all FSMs and valids clear immediately. Array contents are retained, including beats already written. No B response is issued for the aborted burst.
## Test plan
- INCR write at 0x100, len=3, size=3, data 1..4, strb=FF -> bresp=OKAY. Read back -> rdata 1,2,3,4, rresp=OKAY, rlast on beat 4 only.
- WRAP read at 0x118, len=3, size=3 over words holding their own address -> rdata order 0x118, 0x100, 0x108, 0x110.
- Narrow write at 0x203, size=0, strb=0x08, wdata=0xAA000000 over 0x1122334455667788 -> word reads 0x11223344AA667788.
- MEM_ADDR_WIDTH=10: INCR write at 0x1FF8, len=1 -> beat 0 stored, beat 1 dropped, bresp=SLVERR. Read at 0x1FF8, len=1 -> rresp OKAY then SLVERR with rdata 0.
- Stalls and burst types:
  - PIPELINE_OUTPUT=1, len=7 read with rready toggling 1,0,1,0 -> 8 beats in order with stable outputs during stalls.
  - bready held low 5 cycles -> bvalid held and awready low throughout.
  - awburst=11 -> no array change and bresp=SLVERR.

Source files
------------

// File: rtl/axi_sram_burst.sv
// AXI4 slave SRAM model with FIXED/INCR/WRAP bursts, narrow and unaligned beats,
// SLVERR on out-of-range or reserved bursts, and an optional registered R stage.

module axi_sram_burst #(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 8,
  parameter int MEM_ADDR_WIDTH  = 16,
  parameter int PIPELINE_OUTPUT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int STRB     = DATA_WIDTH / 8;
  localparam int OFF      = $clog2(STRB);
  localparam int CAP_BITS = OFF + MEM_ADDR_WIDTH;
  localparam int DEPTH    = 1 << MEM_ADDR_WIDTH;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {WR_IDLE, WR_BURST, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_BURST} rd_state_e;

  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > 3'(OFF)) ? 3'(OFF) : size;
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    if (CAP_BITS >= ADDR_WIDTH) return 1'b1;
    return (addr >> CAP_BITS) == '0;
  endfunction

  function automatic logic [MEM_ADDR_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return MEM_ADDR_WIDTH'(addr >> OFF);
  endfunction

  // Non-legal WRAP lengths fall through to INCR; reserved bursts never touch the array.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [7:0] len,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] bound;
    step  = ADDR_WIDTH'(1) << size;
    bound = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    if (burst == BURST_FIXED) return addr;
    if (burst == BURST_WRAP && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      return (addr & ~(bound - ADDR_WIDTH'(1))) | ((addr + step) & (bound - ADDR_WIDTH'(1)));
    return (addr & ~(step - ADDR_WIDTH'(1))) + step;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  init_q, init_d;
  wr_state_e             wr_state_q, wr_state_d;
  logic [ID_WIDTH-1:0]   wr_id_q, wr_id_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]            wr_len_q, wr_len_d;
  logic [2:0]            wr_size_q, wr_size_d;
  logic [1:0]            wr_burst_q, wr_burst_d;
  logic [7:0]            wr_cnt_q, wr_cnt_d;
  logic                  wr_err_q, wr_err_d;
  logic                  mem_we;
  logic                  wr_beat_ok;

  rd_state_e             rd_state_q, rd_state_d;
  logic [ID_WIDTH-1:0]   rd_id_q, rd_id_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]            rd_len_q, rd_len_d;
  logic [2:0]            rd_size_q, rd_size_d;
  logic [1:0]            rd_burst_q, rd_burst_d;
  logic [7:0]            rd_cnt_q, rd_cnt_d;

  logic                  beat_valid;
  logic                  beat_ok;
  logic [DATA_WIDTH-1:0] beat_data;
  logic [1:0]            beat_resp;
  logic                  beat_last;
  logic                  slot_ready;
  logic                  issue;

  logic unused_sigs;
  assign unused_sigs = s_axi_wlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q     <= 1'b0;
      wr_state_q <= WR_IDLE;
      wr_id_q    <= '0;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
      wr_size_q  <= '0;
      wr_burst_q <= '0;
      wr_cnt_q   <= '0;
      wr_err_q   <= 1'b0;
      rd_state_q <= RD_IDLE;
      rd_id_q    <= '0;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_size_q  <= '0;
      rd_burst_q <= '0;
      rd_cnt_q   <= '0;
    end else begin
      init_q     <= init_d;
      wr_state_q <= wr_state_d;
      wr_id_q    <= wr_id_d;
      wr_addr_q  <= wr_addr_d;
      wr_len_q   <= wr_len_d;
      wr_size_q  <= wr_size_d;
      wr_burst_q <= wr_burst_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_err_q   <= wr_err_d;
      rd_state_q <= rd_state_d;
      rd_id_q    <= rd_id_d;
      rd_addr_q  <= rd_addr_d;
      rd_len_q   <= rd_len_d;
      rd_size_q  <= rd_size_d;
      rd_burst_q <= rd_burst_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  assign init_d     = 1'b1;
  assign wr_beat_ok = in_range(wr_addr_q) && (wr_burst_q != BURST_RSVD);

  always_comb begin
    wr_state_d    = wr_state_q;
    wr_id_d       = wr_id_q;
    wr_addr_d     = wr_addr_q;
    wr_len_d      = wr_len_q;
    wr_size_d     = wr_size_q;
    wr_burst_d    = wr_burst_q;
    wr_cnt_d      = wr_cnt_q;
    wr_err_d      = wr_err_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    mem_we        = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        s_axi_awready = init_q;
        if (init_q && s_axi_awvalid) begin
          wr_id_d    = s_axi_awid;
          wr_addr_d  = s_axi_awaddr;
          wr_len_d   = s_axi_awlen;
          wr_size_d  = clamp_size(s_axi_awsize);
          wr_burst_d = s_axi_awburst;
          wr_cnt_d   = '0;
          wr_err_d   = 1'b0;
          wr_state_d = WR_BURST;
        end
      end
      WR_BURST: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          mem_we    = wr_beat_ok;
          wr_err_d  = wr_err_q | ~wr_beat_ok;
          wr_addr_d = next_addr(wr_addr_q, wr_len_q, wr_size_q, wr_burst_q);
          wr_cnt_d  = wr_cnt_q + 8'd1;
          if (wr_cnt_q == wr_len_q) wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  assign s_axi_bid   = wr_id_q;
  assign s_axi_bresp = wr_err_q ? RESP_SLVERR : RESP_OKAY;

  // The array has no reset so contents survive a mid-burst rst_n pulse.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB; b++) begin
        if (s_axi_wstrb[b]) mem[word_idx(wr_addr_q)][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  assign beat_valid = (rd_state_q == RD_BURST);
  assign beat_ok    = in_range(rd_addr_q) && (rd_burst_q != BURST_RSVD);
  assign beat_data  = beat_ok ? mem[word_idx(rd_addr_q)] : '0;
  assign beat_resp  = beat_ok ? RESP_OKAY : RESP_SLVERR;
  assign beat_last  = (rd_cnt_q == rd_len_q);
  assign issue      = beat_valid && slot_ready;

  always_comb begin
    rd_state_d    = rd_state_q;
    rd_id_d       = rd_id_q;
    rd_addr_d     = rd_addr_q;
    rd_len_d      = rd_len_q;
    rd_size_d     = rd_size_q;
    rd_burst_d    = rd_burst_q;
    rd_cnt_d      = rd_cnt_q;
    s_axi_arready = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        s_axi_arready = init_q;
        if (init_q && s_axi_arvalid) begin
          rd_id_d    = s_axi_arid;
          rd_addr_d  = s_axi_araddr;
          rd_len_d   = s_axi_arlen;
          rd_size_d  = clamp_size(s_axi_arsize);
          rd_burst_d = s_axi_arburst;
          rd_cnt_d   = '0;
          rd_state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        if (issue) begin
          rd_addr_d = next_addr(rd_addr_q, rd_len_q, rd_size_q, rd_burst_q);
          rd_cnt_d  = rd_cnt_q + 8'd1;
          if (beat_last) rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  generate
    if (PIPELINE_OUTPUT != 0) begin : g_pipe
      logic                  out_valid_q, out_valid_d;
      logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
      logic [1:0]            out_resp_q, out_resp_d;
      logic                  out_last_q, out_last_d;
      logic [ID_WIDTH-1:0]   out_id_q, out_id_d;

      // Slot refills in the same cycle it drains, so rready held high gives no bubbles.
      always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_resp_d  = out_resp_q;
        out_last_d  = out_last_q;
        out_id_d    = out_id_q;
        if (issue) begin
          out_valid_d = 1'b1;
          out_data_d  = beat_data;
          out_resp_d  = beat_resp;
          out_last_d  = beat_last;
          out_id_d    = rd_id_q;
        end else if (s_axi_rready) begin
          out_valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
          out_resp_q  <= '0;
          out_last_q  <= 1'b0;
          out_id_q    <= '0;
        end else begin
          out_valid_q <= out_valid_d;
          out_data_q  <= out_data_d;
          out_resp_q  <= out_resp_d;
          out_last_q  <= out_last_d;
          out_id_q    <= out_id_d;
        end
      end

      assign slot_ready   = !out_valid_q || s_axi_rready;
      assign s_axi_rvalid = out_valid_q;
      assign s_axi_rdata  = out_data_q;
      assign s_axi_rresp  = out_resp_q;
      assign s_axi_rlast  = out_last_q;
      assign s_axi_rid    = out_id_q;
    end else begin : g_comb
      assign slot_ready   = s_axi_rready;
      assign s_axi_rvalid = beat_valid;
      assign s_axi_rdata  = beat_valid ? beat_data : '0;
      assign s_axi_rresp  = beat_valid ? beat_resp : RESP_OKAY;
      assign s_axi_rlast  = beat_valid && beat_last;
      assign s_axi_rid    = rd_id_q;
    end
  endgenerate

endmodule
